// File: rtl/state_seq_gen_if.sv
// Shared state bus between the sequence generator and the transition checker.
// The generator owns every signal on this bus.
interface state_seq_gen_if #(
  parameter int CW = 16
);
  logic [3:0]    state;
  logic          state_vld;
  logic          done;
  logic          err_injected;
  logic [CW-1:0] trans_cnt;

  modport master (
    output state,
    output state_vld,
    output done,
    output err_injected,
    output trans_cnt
  );

  modport slave (
    input state,
    input state_vld,
    input done,
    input err_injected,
    input trans_cnt
  );
endinterface

// File: rtl/state_seq_gen.sv
// Walks the legal state graph one hop per step, with LFSR or directed
// branch choice, programmable dwell and one-shot illegal-hop injection.
module state_seq_gen #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter int         DW   = 8,
  parameter int         CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          mode,
  input  logic [1:0]    sel,
  input  logic [DW-1:0] dwell,
  input  logic          restart,
  input  logic          inject_err,
  state_seq_gen_if.master ix
);

  typedef enum logic [3:0] {
    S0  = 4'd0,
    S1  = 4'd1,
    S2  = 4'd2,
    S3  = 4'd3,
    S4  = 4'd4,
    S5  = 4'd5,
    S6  = 4'd6,
    S7  = 4'd7,
    S8  = 4'd8,
    S9  = 4'd9,
    S10 = 4'd10
  } st_t;

  localparam logic [7:0] L_SEED =
    (SEED == 8'h00) ? 8'hA5 : SEED;

  st_t           state_q, state_d;
  st_t           succ, tgt;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          vld_q, vld_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic [1:0]    c;
  logic          step;

  // x^8+x^6+x^5+x^4+1, right-shifting Galois form
  assign lfsr_d = {1'b0, lfsr_q[7:1]}
                ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  assign c    = mode ? sel : lfsr_q[1:0];
  assign step = en & ~done_q & ~restart
              & (dwell_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S0;
      dwell_q <= '0;
      cnt_q   <= '0;
      lfsr_q  <= L_SEED;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    succ = state_q;
    case (state_q)
      S0:      succ = S1;
      S1:      succ = c[0] ? S4 : S2;
      S2:      succ = S3;
      S3:      succ = c[0] ? S5 : S1;
      S4:      succ = S5;
      S5:      succ = c[0] ? S6 : S1;
      S6:      succ = S7;
      S7:      succ = S8;
      S8: begin
        case (c)
          2'd0:    succ = S2;
          2'd1:    succ = S4;
          2'd2:    succ = S9;
          default: succ = S10;
        endcase
      end
      S9:      succ = S8;
      default: succ = state_q;
    endcase
  end

  // Injected hops land on 6, or on 3 from 5 (where 6 is legal)
  always_comb begin
    tgt = succ;
    if (inject_err)
      tgt = (state_q == S5) ? S3 : S6;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = (dwell_q == '0) ? '0
            : dwell_q - DW'(1);
    unique case (1'b1)
      restart: begin
        state_d = S0;
        dwell_d = '0;
      end
      step: begin
        state_d = tgt;
        dwell_d = dwell;
        cnt_d   = (&cnt_q) ? cnt_q
                : cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    vld_d  = step;
    err_d  = step & inject_err;
    done_d = (state_d == S10);
  end

  assign ix.state        = state_q;
  assign ix.state_vld    = vld_q;
  assign ix.done         = done_q;
  assign ix.err_injected = err_q;
  assign ix.trans_cnt    = cnt_q;

endmodule
